// File: rtl/spi_pkg.sv
// Shared constants for the SPI initiator: command encodings, frame sizes,
// FSM state encoding, and the command-sequence legality helper.
// No ports; imported by spi_master and spi_master_rx.
package spi_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int FRAME_BITS = 10;  // {cmd[1:0], din[7:0]}
  localparam int DATA_BITS  = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SEL   = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_TURN  = 3'd3;
  localparam logic [2:0] ST_RECV  = 3'd4;
  localparam logic [2:0] ST_STOP  = 3'd5;
  localparam logic [2:0] ST_GAP   = 3'd6;

  // A data command must directly follow its matching address command.
  function automatic logic seq_legal(input logic       prev_vld,
                                     input logic [1:0] prev_cmd,
                                     input logic [1:0] cmd);
    case (cmd)
      CMD_WR_DATA: return prev_vld && (prev_cmd == CMD_WR_ADDR);
      CMD_RD_DATA: return prev_vld && (prev_cmd == CMD_RD_ADDR);
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/spi_master_rx.sv
// MISO deserialiser: shifts miso in MSB first while enabled, and captures the
// completed byte (including the bit arriving this cycle) when load_i is high.
// Ports: clk/rst_n, shift_en_i, load_i, miso_i in; data_o out (held between loads).
module spi_master_rx
  import spi_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 shift_en_i,
  input  logic                 load_i,
  input  logic                 miso_i,
  output logic [DATA_BITS-1:0] data_o
);

  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [DATA_BITS-1:0] data_q;

  assign shift_d = {shift_q[DATA_BITS-2:0], miso_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      data_q  <= '0;
    end else begin
      if (shift_en_i) shift_q <= shift_d;
      // Load from shift_d so the last bit lands in data_q on the same edge.
      if (load_i)     data_q  <= shift_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/spi_master.sv
// SPI initiator: turns one {cmd, din} request into one slave frame on ss_n/mosi,
// and for read-data frames returns the byte shifted in on miso.
// Latency: 11 ss_n-low cycles (19+TURNAROUND for cmd 11), then GAP high cycles.
// Backpressure: start is only accepted while busy=0; no queueing.
// Ports: clk, rst_n, start, cmd[1:0], din[7:0], miso in;
//        busy, done, rx_data[7:0], rx_valid, err, ss_n, mosi out.
// Optional: SPI_MASTER_SEQ_CHECK_EN rejects out-of-order data commands with err.
module spi_master
  import spi_pkg::*;
#(
  parameter int TURNAROUND = 1,
  parameter int GAP        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       err,
  output logic       ss_n,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [3:0]  SHIFT_LAST = 4'(FRAME_BITS - 1);
  localparam logic [3:0]  RECV_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]  TURN_LAST  = 4'((TURNAROUND >= 1) ? TURNAROUND - 1 : 0);
  localparam logic [15:0] GAP_LAST   = 16'((GAP >= 2) ? GAP - 2 : 0);

  logic [2:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [15:0]           gap_q, gap_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [1:0]            cmd_q, cmd_d;
  logic                  start_ok;

`ifdef SPI_MASTER_SEQ_CHECK_EN
  logic       hist_vld_q;
  logic [1:0] hist_cmd_q;
  logic       err_q;
  logic       seq_ok;

  assign seq_ok   = seq_legal(hist_vld_q, hist_cmd_q, cmd);
  assign start_ok = start && seq_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_vld_q <= 1'b0;
      hist_cmd_q <= 2'b00;
      err_q      <= 1'b0;
    end else begin
      err_q <= start && (state_q == ST_IDLE) && !seq_ok;
      if (start_ok && (state_q == ST_IDLE)) begin
        hist_vld_q <= 1'b1;
        hist_cmd_q <= cmd;
      end
    end
  end

  assign err = err_q;
`else
  assign start_ok = start;
  assign err      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    tx_d    = tx_q;
    cmd_d   = cmd_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          tx_d    = {cmd, din};
          cmd_d   = cmd;
          cnt_d   = 4'd0;
          state_d = ST_SEL;
        end
      end
      // SEL presents cmd[1] early without shifting; SHIFT then sends all 10 bits.
      ST_SEL: state_d = ST_SHIFT;
      ST_SHIFT: begin
        tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
        if (cnt_q == SHIFT_LAST) begin
          cnt_d = 4'd0;
          if (cmd_q != CMD_RD_DATA)  state_d = ST_STOP;
          else if (TURNAROUND == 0)  state_d = ST_RECV;
          else                       state_d = ST_TURN;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_TURN: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d   = 4'd0;
          state_d = ST_RECV;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RECV: begin
        if (cnt_q == RECV_LAST) begin
          cnt_d   = 4'd0;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_STOP: begin
        gap_d   = 16'd0;
        state_d = (GAP <= 1) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else                   gap_d   = gap_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      gap_q   <= 16'd0;
      tx_q    <= '0;
      cmd_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      tx_q    <= tx_d;
      cmd_q   <= cmd_d;
    end
  end

  // Outputs decode the state register directly so async reset clears them at once.
  assign ss_n     = !((state_q == ST_SEL) || (state_q == ST_SHIFT) ||
                      (state_q == ST_TURN) || (state_q == ST_RECV));
  assign mosi     = ((state_q == ST_SEL) || (state_q == ST_SHIFT)) && tx_q[FRAME_BITS-1];
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_STOP);
  assign rx_valid = done && (cmd_q == CMD_RD_DATA);

  spi_master_rx u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en_i (state_q == ST_RECV),
    .load_i     ((state_q == ST_RECV) && (cnt_q == RECV_LAST)),
    .miso_i     (miso),
    .data_o     (rx_data)
  );

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: reset, write/read frames with a slave model on
// miso, back-to-back requests, start-while-busy, reset mid-frame, and (when
// SPI_MASTER_SEQ_CHECK_EN is defined) the command-sequence check.
module tb_spi_master;

  localparam int TA = 1;
  localparam int GP = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [7:0] din = 8'h00;
  logic       miso = 1'b0;
  logic       busy, done, rx_valid, err, ss_n, mosi;
  logic [7:0] rx_data;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_master #(.TURNAROUND(TA), .GAP(GP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .din(din),
    .busy(busy), .done(done), .rx_data(rx_data), .rx_valid(rx_valid),
    .err(err), .ss_n(ss_n), .mosi(mosi), .miso(miso)
  );

  // Called on a negedge; issues one request and records the frame until busy drops.
  // inj >= 0 pulses a second start (cmd 10, din 00) at that ss_n-low cycle index.
  task automatic run_frame(input logic [1:0] c, input logic [7:0] d, input logic [7:0] sb,
                           input int inj, output logic [31:0] bits, output int nlow,
                           output int ndone, output int nrxv, output logic [7:0] rxd,
                           output int ngap, output int nerr);
    int k;
    int i;
    bits = '0; nlow = 0; ndone = 0; nrxv = 0; rxd = 8'h00; ngap = 0; nerr = 0;
    start = 1'b1; cmd = c; din = d;
    @(negedge clk);
    start = 1'b0;
    i = 0;
    while (busy === 1'b1 && i < 80) begin
      start = 1'b0;
      if (err === 1'b1) nerr++;
      if (ss_n === 1'b0) begin
        k = nlow;
        bits = {bits[30:0], mosi};
        nlow++;
        miso = (k >= 11 + TA && k < 19 + TA) ? sb[7 - (k - 11 - TA)] : 1'b0;
        if (k == inj) begin start = 1'b1; cmd = 2'b10; din = 8'h00; end
      end else if (nlow > 0) begin
        ngap++;
      end
      if (done === 1'b1) begin ndone++; rxd = rx_data; end
      if (rx_valid === 1'b1) nrxv++;
      @(negedge clk);
      i++;
    end
    miso = 1'b0;
    start = 1'b0;
    n_assert++;
    if (i >= 80) begin
      n_fail++;
      $display("FAIL frame_timeout: busy still %b after 80 cycles, required 0", busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_assert++; if (ss_n !== 1'b1)      begin n_fail++; $display("FAIL reset_ss_n: got %b, required 1", ss_n); end
    n_assert++; if (mosi !== 1'b0)      begin n_fail++; $display("FAIL reset_mosi: got %b, required 0", mosi); end
    n_assert++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_assert++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
    n_assert++; if (rx_data !== 8'h00)  begin n_fail++; $display("FAIL reset_rx_data: got %h, required 00", rx_data); end
    n_assert++; if (rx_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_rx_valid: got %b, required 0", rx_valid); end
    n_assert++; if (err !== 1'b0)       begin n_fail++; $display("FAIL reset_err: got %b, required 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_wr_addr();
    logic [31:0] bits; logic [7:0] rxd; int nlow, ndone, nrxv, ngap, nerr;
    run_frame(2'b00, 8'hFF, 8'h00, -1, bits, nlow, ndone, nrxv, rxd, ngap, nerr);
    n_assert++; if (nlow !== 11)            begin n_fail++; $display("FAIL wr_addr_len: got %0d, required 11", nlow); end
    n_assert++; if (bits[10:0] !== 11'h0FF) begin n_fail++; $display("FAIL wr_addr_mosi: got %h, required 0ff", bits[10:0]); end
    n_assert++; if (ndone !== 1)            begin n_fail++; $display("FAIL wr_addr_done: got %0d, required 1", ndone); end
    n_assert++; if (nrxv !== 0)             begin n_fail++; $display("FAIL wr_addr_rx_valid: got %0d, required 0", nrxv); end
    n_assert++; if (ngap !== GP)            begin n_fail++; $display("FAIL wr_addr_gap: got %0d, required %0d", ngap, GP); end
    n_assert++; if (nerr !== 0)             begin n_fail++; $display("FAIL wr_addr_err: got %0d, required 0", nerr); end
  endtask

  // Called immediately after the 00 frame so each start lands on the first IDLE cycle.
  task automatic test_back_to_back();
    logic [31:0] bits; logic [7:0] rxd; int nlow, ndone, nrxv, ngap, nerr;
    run_frame(2'b01, 8'hFF, 8'h00, -1, bits, nlow, ndone, nrxv, rxd, ngap, nerr);
    n_assert++; if (nlow !== 11)            begin n_fail++; $display("FAIL wr_data_len: got %0d, required 11", nlow); end
    n_assert++; if (bits[10:0] !== 11'h1FF) begin n_fail++; $display("FAIL wr_data_mosi: got %h, required 1ff", bits[10:0]); end
    n_assert++; if (ndone !== 1)            begin n_fail++; $display("FAIL wr_data_done: got %0d, required 1", ndone); end
    n_assert++; if (ngap !== GP)            begin n_fail++; $display("FAIL wr_data_gap: got %0d, required %0d", ngap, GP); end
    run_frame(2'b10, 8'hFF, 8'h00, -1, bits, nlow, ndone, nrxv, rxd, ngap, nerr);
    n_assert++; if (nlow !== 11)            begin n_fail++; $display("FAIL rd_addr_len: got %0d, required 11", nlow); end
    n_assert++; if (bits[10:0] !== 11'h6FF) begin n_fail++; $display("FAIL rd_addr_mosi: got %h, required 6ff", bits[10:0]); end
    n_assert++; if (nrxv !== 0)             begin n_fail++; $display("FAIL rd_addr_rx_valid: got %0d, required 0", nrxv); end
  endtask

  task automatic test_rd_data();
    logic [31:0] bits; logic [7:0] rxd; int nlow, ndone, nrxv, ngap, nerr;
    run_frame(2'b11, 8'h00, 8'hA5, -1, bits, nlow, ndone, nrxv, rxd, ngap, nerr);
    n_assert++; if (nlow !== 19 + TA)         begin n_fail++; $display("FAIL rd_data_len: got %0d, required %0d", nlow, 19 + TA); end
    n_assert++; if (bits[19:0] !== 20'hE0000) begin n_fail++; $display("FAIL rd_data_mosi: got %h, required e0000", bits[19:0]); end
    n_assert++; if (ndone !== 1)              begin n_fail++; $display("FAIL rd_data_done: got %0d, required 1", ndone); end
    n_assert++; if (nrxv !== 1)               begin n_fail++; $display("FAIL rd_data_rx_valid: got %0d, required 1", nrxv); end
    n_assert++; if (rxd !== 8'hA5)            begin n_fail++; $display("FAIL rd_data_at_done: got %h, required a5", rxd); end
    n_assert++; if (nerr !== 0)               begin n_fail++; $display("FAIL rd_data_err: got %0d, required 0", nerr); end
    repeat (3) @(negedge clk);
    n_assert++; if (rx_data !== 8'hA5)        begin n_fail++; $display("FAIL rd_data_hold: got %h, required a5", rx_data); end
    n_assert++; if (rx_valid !== 1'b0)        begin n_fail++; $display("FAIL rd_data_valid_idle: got %b, required 0", rx_valid); end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] bits; logic [7:0] rxd; int nlow, ndone, nrxv, ngap, nerr, nlate;
    run_frame(2'b00, 8'h3C, 8'h00, 4, bits, nlow, ndone, nrxv, rxd, ngap, nerr);
    n_assert++; if (bits[10:0] !== 11'h03C) begin n_fail++; $display("FAIL busy_start_mosi: got %h, required 03c", bits[10:0]); end
    n_assert++; if (ndone !== 1)            begin n_fail++; $display("FAIL busy_start_done: got %0d, required 1", ndone); end
    nlate = 0;
    for (int i = 0; i < 20; i++) begin
      if (ss_n !== 1'b1 || busy !== 1'b0) nlate++;
      @(negedge clk);
    end
    n_assert++; if (nlate !== 0)            begin n_fail++; $display("FAIL busy_start_queued: got %0d active cycles, required 0", nlate); end
  endtask

  task automatic test_reset_mid_frame();
    int nact;
    start = 1'b1; cmd = 2'b00; din = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    n_assert++; if (ss_n !== 1'b0)     begin n_fail++; $display("FAIL midrst_pre_ss_n: got %b, required 0", ss_n); end
    #2 rst_n = 1'b0;
    #1;
    n_assert++; if (ss_n !== 1'b1)     begin n_fail++; $display("FAIL midrst_ss_n: got %b, required 1", ss_n); end
    n_assert++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    n_assert++; if (mosi !== 1'b0)     begin n_fail++; $display("FAIL midrst_mosi: got %b, required 0", mosi); end
    n_assert++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_rx_data: got %h, required 00", rx_data); end
    @(negedge clk);
    rst_n = 1'b1;
    nact = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || ss_n !== 1'b1) nact++;
    end
    n_assert++; if (nact !== 0)        begin n_fail++; $display("FAIL midrst_no_done: got %0d active cycles, required 0", nact); end
  endtask

`ifdef SPI_MASTER_SEQ_CHECK_EN
  task automatic test_seq_check();
    logic [31:0] bits; logic [7:0] rxd; int nlow, ndone, nrxv, ngap, nerr;
    start = 1'b1; cmd = 2'b11; din = 8'h00;
    @(negedge clk);
    start = 1'b0;
    n_assert++; if (err !== 1'b1)  begin n_fail++; $display("FAIL seq_err_pulse: got %b, required 1", err); end
    n_assert++; if (ss_n !== 1'b1) begin n_fail++; $display("FAIL seq_err_ss_n: got %b, required 1", ss_n); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL seq_err_busy: got %b, required 0", busy); end
    @(negedge clk);
    n_assert++; if (err !== 1'b0)  begin n_fail++; $display("FAIL seq_err_width: got %b, required 0", err); end
    run_frame(2'b10, 8'hF0, 8'h00, -1, bits, nlow, ndone, nrxv, rxd, ngap, nerr);
    n_assert++; if (bits[10:0] !== 11'h6F0) begin n_fail++; $display("FAIL seq_rd_addr_mosi: got %h, required 6f0", bits[10:0]); end
    n_assert++; if (nerr !== 0)  begin n_fail++; $display("FAIL seq_rd_addr_err: got %0d, required 0", nerr); end
    run_frame(2'b11, 8'h00, 8'h3C, -1, bits, nlow, ndone, nrxv, rxd, ngap, nerr);
    n_assert++; if (nlow !== 19 + TA) begin n_fail++; $display("FAIL seq_rd_data_len: got %0d, required %0d", nlow, 19 + TA); end
    n_assert++; if (rxd !== 8'h3C)    begin n_fail++; $display("FAIL seq_rd_data: got %h, required 3c", rxd); end
    n_assert++; if (nerr !== 0)       begin n_fail++; $display("FAIL seq_rd_data_err: got %0d, required 0", nerr); end
  endtask
`endif

  initial begin
    test_reset();
    test_wr_addr();
    test_back_to_back();
    test_rd_data();
    test_start_while_busy();
    test_reset_mid_frame();
`ifdef SPI_MASTER_SEQ_CHECK_EN
    test_seq_check();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
